// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit beside the ALU. It owns the HI/LO registers.
// Results are computed at accept and held in temp_hi/temp_lo, then committed after N cycles.
module mdu_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Src1,
  input  logic [31:0] Src2,
  input  logic [3:0]  MDOP,
  input  logic        Start,
  output logic        Busy,
  output logic [31:0] Result,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAXC = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int CW   = $clog2(MAXC) + 1;

  typedef enum logic {IDLE, RUN} state_e;

  state_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] thi_q, thi_d, tlo_q, tlo_d;
  logic        nowb_q, nowb_d;

  logic        is_mul, is_div, accept;
  logic [63:0] ext1, ext2, prod;
  logic        dsgn, neg1, neg2, dvz;
  logic [31:0] abs1, abs2, dsafe, q_abs, r_abs, quo, rem;

  assign is_mul = (MDOP == 4'd1) || (MDOP == 4'd2);
  assign is_div = (MDOP == 4'd3) || (MDOP == 4'd4);
  assign accept = (state_q == IDLE) && Start;

  // Low 64 bits of the product of sign-extended operands equal the signed product.
  assign ext1 = (MDOP == 4'd1) ? {{32{Src1[31]}}, Src1} : {32'd0, Src1};
  assign ext2 = (MDOP == 4'd1) ? {{32{Src2[31]}}, Src2} : {32'd0, Src2};
  assign prod = ext1 * ext2;

  // Signed divide on magnitudes. This keeps 0x80000000 / -1 well defined (q=0x80000000, r=0).
  assign dsgn  = (MDOP == 4'd3);
  assign neg1  = dsgn & Src1[31];
  assign neg2  = dsgn & Src2[31];
  assign abs1  = neg1 ? -Src1 : Src1;
  assign abs2  = neg2 ? -Src2 : Src2;
  assign dvz   = (Src2 == 32'd0);
  assign dsafe = dvz ? 32'd1 : abs2;
  assign q_abs = abs1 / dsafe;
  assign r_abs = abs1 % dsafe;
  assign quo   = (neg1 ^ neg2) ? -q_abs : q_abs;
  assign rem   = neg1 ? -r_abs : r_abs;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    thi_d   = thi_q;
    tlo_d   = tlo_q;
    nowb_d  = nowb_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_mul) begin
            thi_d   = prod[63:32];
            tlo_d   = prod[31:0];
            nowb_d  = 1'b0;
            cnt_d   = CW'(MULT_CYCLES - 1);
            state_d = RUN;
          end else if (is_div) begin
            thi_d   = rem;
            tlo_d   = quo;
            nowb_d  = dvz;
            cnt_d   = CW'(DIV_CYCLES - 1);
            state_d = RUN;
          end else if (MDOP == 4'd7) begin
            hi_d = Src1;
          end else if (MDOP == 4'd8) begin
            lo_d = Src1;
          end
        end
      end
      RUN: begin
        if (cnt_q == '0) begin
          if (!nowb_q) begin
            hi_d = thi_q;
            lo_d = tlo_q;
          end
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      thi_q   <= '0;
      tlo_q   <= '0;
      nowb_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      thi_q   <= thi_d;
      tlo_q   <= tlo_d;
      nowb_q  <= nowb_d;
    end
  end

  assign Busy   = (state_q == RUN);
  assign HI     = hi_q;
  assign LO     = lo_q;
  assign Result = (MDOP == 4'd5) ? hi_q : (MDOP == 4'd6) ? lo_q : 32'd0;

endmodule

// File: tb/tb_mdu_unit.sv
// Scoreboard bench for mdu_unit: each issued mult/div pushes its expected HI/LO and Busy length.
// A monitor pops an entry and checks it when Busy falls.
module tb_mdu_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Src1, Src2;
  logic [3:0]  MDOP;
  logic        Start;
  logic        Busy;
  logic [31:0] Result, HI, LO;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          len;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   abort  = 1'b0;

  mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .Src1(Src1), .Src2(Src2), .MDOP(MDOP),
    .Start(Start), .Busy(Busy), .Result(Result), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %08h want %08h", name, act, exp);
    end
  endtask

  // Monitor: counts Busy cycles and checks the committed HI/LO when Busy drops.
  initial begin
    int  bcnt = 0;
    bit  prev = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (Busy) bcnt++;
      else if (prev) begin
        if (abort) abort = 1'b0;
        else if (exp_q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("busy_len", 32'(bcnt), 32'(e.len));
          chk("hi", HI, e.hi);
          chk("lo", LO, e.lo);
        end
        bcnt = 0;
      end
      prev = Busy;
    end
  end

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    MDOP = op; Src1 = a; Src2 = b; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0; MDOP = 4'd0; Src1 = $urandom; Src2 = $urandom;
  endtask

  task automatic push(input logic [31:0] h, input logic [31:0] l, input int n);
    exp_t e;
    e.hi = h; e.lo = l; e.len = n;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!Busy) break;
    end
    if (i == 40) chk("idle_timeout", 32'd1, 32'd0);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; Src1 = '0; Src2 = '0; MDOP = 4'd5; Start = 1'b0;
    #2;
    chk("rst_hi", HI, 32'h0);
    chk("rst_lo", LO, 32'h0);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_result", Result, 32'h0);
    #20 reset = 1'b0;

    // Mid-cycle reset must clear HI immediately.
    issue(4'd7, 32'hCAFEF00D, 32'h0);
    chk("mthi", HI, 32'hCAFEF00D);
    #2 reset = 1'b1;
    #1 chk("async_rst_hi", HI, 32'h0);
    reset = 1'b0;

    push(32'hFFFFFFFF, 32'hFFFFFFFA, 5);
    issue(4'd1, 32'hFFFFFFFE, 32'd3);
    wait_idle();
    MDOP = 4'd5; #1 chk("mfhi", Result, 32'hFFFFFFFF);
    MDOP = 4'd6; #1 chk("mflo", Result, 32'hFFFFFFFA);
    MDOP = 4'd9; #1 chk("result_other", Result, 32'h0);
    MDOP = 4'd0;

    push(32'h00000002, 32'hFFFFFFFA, 5);
    issue(4'd2, 32'hFFFFFFFE, 32'd3);
    wait_idle();

    push(32'hFFFFFFFF, 32'hFFFFFFFD, 10);
    issue(4'd3, 32'hFFFFFFF9, 32'd2);
    wait_idle();

    push(32'd1, 32'd3, 10);
    issue(4'd4, 32'd7, 32'd2);
    wait_idle();

    push(32'h0, 32'h80000000, 10);
    issue(4'd3, 32'h80000000, 32'hFFFFFFFF);
    wait_idle();

    // Divide by zero keeps the preloaded HI/LO.
    issue(4'd7, 32'h11111111, 32'h0);
    issue(4'd8, 32'h22222222, 32'h0);
    chk("mt_busy", 32'(Busy), 32'd0);
    chk("mthi_val", HI, 32'h11111111);
    chk("mtlo_val", LO, 32'h22222222);
    push(32'h11111111, 32'h22222222, 10);
    issue(4'd3, 32'd55, 32'd0);
    wait_idle();
    push(32'h11111111, 32'h22222222, 10);
    issue(4'd4, 32'd55, 32'd0);
    wait_idle();

    // Collisions during a running mult are ignored.
    push(32'h0, 32'd42, 5);
    issue(4'd1, 32'd6, 32'd7);
    @(posedge clk); #1;
    MDOP = 4'd7; Src1 = 32'hDEADBEEF; Start = 1'b1;
    @(posedge clk); #1;
    MDOP = 4'd1; Src1 = 32'd100; Src2 = 32'd100;
    @(posedge clk); #1;
    Start = 1'b0; MDOP = 4'd0;
    wait_idle();

    // Reset in the third cycle of a divide aborts the commit.
    issue(4'd3, 32'd100, 32'd7);
    @(posedge clk);
    @(posedge clk); #3;
    abort = 1'b1;
    reset = 1'b1;
    #1;
    chk("abort_busy", 32'(Busy), 32'd0);
    chk("abort_hi", HI, 32'h0);
    chk("abort_lo", LO, 32'h0);
    reset = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("abort_hi_late", HI, 32'h0);
    chk("abort_lo_late", LO, 32'h0);

    push(32'hFFFFFFFF, 32'hFFFFFFFB, 5);
    issue(4'd1, 32'd5, 32'hFFFFFFFF);
    wait_idle();

    repeat (2) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Multi-cycle multiply/divide unit in the EX stage, beside the ALU.
- Takes the same forwarded operands as the ALU (Src1/Src2) and owns the architectural HI/LO registers.
- Its Result output is muxed with the ALU result into the EX/MEM register.
- Busy tells the hazard unit to stall any multiply/divide-class instruction in D.

Parameters:
MULT_CYCLES, 5, cycles from accepted mult/multu to HI/LO update (>=1)
DIV_CYCLES, 10, cycles from accepted div/divu to HI/LO update (>=1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high; clears all state
Src1  input  32  operand rs (forwarded)
Src2  input  32  operand rt (forwarded)
MDOP  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 9-15 none
Start  input  1  qualifies write-class ops (1,2,3,4,7,8) this cycle
Busy  output  1  operation in flight
Result  output  32  combinational: HI if MDOP=5, LO if MDOP=6, else 0
HI  output  32  architectural HI register
LO  output  32  architectural LO register

Behaviour:
- Reset (async, any time): HI=0, LO=0, Busy=0, counter=0, pending results discarded. Takes effect immediately, not at the next edge.
- States: IDLE, RUN.
- IDLE, Start=1, MDOP in 1-4 (accept edge T):
  - Compute the result and latch it into internal temp_hi/temp_lo.
  - Load counter = N-1 (N = MULT_CYCLES or DIV_CYCLES); go to RUN.
  - Busy=1 after edge T.
- RUN: counter decrements each edge.
  - At edge T+N: HI/LO <= temp_hi/temp_lo, Busy<=0, go to IDLE.
  - Busy is high for exactly N cycles.
- mult: signed 32x32 -> 64; HI = bits 63:32, LO = bits 31:0.
- multu: same, unsigned.
- div: signed; LO = quotient truncated toward zero; HI = remainder, sign of dividend (Src1).
- divu: unsigned quotient and remainder.
- div overflow, 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Division by zero (div or divu):
  - Busy behaves normally for DIV_CYCLES.
  - HI and LO unchanged at completion.
- mthi/mtlo (Start=1, MDOP 7/8, IDLE only): HI (or LO) <= Src1 at that edge; single cycle; Busy stays 0.
- Ops arriving while Busy=1:
  - Start=1 with any write-class op is ignored: no state change, in-flight op unaffected.
  - The hazard unit guarantees this never happens architecturally; the block must still be robust to it.
- mfhi/mflo:
  - Result is purely combinational from current HI/LO; Start is not required.
  - While Busy=1, Result shows the old HI/LO. The stall is the hazard unit's job.
- Start=1 with MDOP 0, 5, 6 or 9-15: no effect.
- Result is 0 for any MDOP other than 5 and 6.
- Operands are sampled only at the accept edge; Src1/Src2 changes during RUN have no effect.

Test Plan:
- Reset then idle: reset pulse mid-cycle -> HI=LO=0, Busy=0 immediately; Result=0 with MDOP=5.
- mult: Src1=0xFFFFFFFE (-2), Src2=3, MDOP=1, Start one cycle -> Busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA. Repeat with multu -> HI=0x00000002, LO=0xFFFFFFFA.
- div: Src1=-7 (0xFFFFFFF9), Src2=2, MDOP=3 -> after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 7/2 -> LO=3, HI=1. Overflow case 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- Divide by zero: HI=0x11111111, LO=0x22222222 preloaded via mthi/mtlo, then div by 0 -> Busy 10 cycles; HI/LO unchanged.
- Collisions while Busy:
  - mthi Src1=0xDEADBEEF with Start=1 during a running mult -> ignored; HI ends at the mult result.
  - Second mult started during RUN -> ignored; Busy does not extend.
- Reset mid-operation: assert reset at cycle 3 of a div -> Busy=0, HI=LO=0, no later update. A fresh mult afterwards completes normally.
